// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP datapath.
//   DATA_W / ADDR_W / FRAC_BITS : default datapath, address and fraction widths
//   state_e                     : neuron compute FSM states
//   QMAX / QMIN                 : Q8.8 saturation limits
package mlp_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 12;
  localparam int FRAC_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    WRITE  = 2'd3
  } state_e;

  localparam logic signed [15:0] QMAX = 16'sh7FFF;
  localparam logic signed [15:0] QMIN = 16'sh8000;

endpackage : mlp_pkg

// File: rtl/sat_relu.sv
// Combinational result formatter: shifts a wide signed accumulator down by
// FRAC_BITS (arithmetic, rounding toward -inf), saturates to the signed
// DATA_W range and optionally clamps negatives to zero.
//   acc_i   : signed ACC_W accumulator
//   relu_i  : apply ReLU
//   data_o  : signed DATA_W formatted result
module sat_relu #(
  parameter int ACC_W     = 48,
  parameter int DATA_W    = mlp_pkg::DATA_W,
  parameter int FRAC_BITS = mlp_pkg::FRAC_BITS
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic                     relu_i,
  output logic signed [DATA_W-1:0] data_o
);

  // Saturation bounds expressed at accumulator width so the compare is exact.
  localparam logic signed [ACC_W-1:0] LIM_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LIM_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] shift_sat_relu(
    input logic signed [ACC_W-1:0] a,
    input logic                    relu
  );
    logic signed [ACC_W-1:0]  r;
    logic signed [DATA_W-1:0] y;
    r = a >>> FRAC_BITS;
    if (r > LIM_MAX) begin
      y = LIM_MAX[DATA_W-1:0];
    end else if (r < LIM_MIN) begin
      y = LIM_MIN[DATA_W-1:0];
    end else begin
      y = r[DATA_W-1:0];
    end
    if (relu && y[DATA_W-1]) begin
      y = '0;
    end
    return y;
  endfunction

  assign data_o = shift_sat_relu(acc_i, relu_i);

endmodule : sat_relu

// File: rtl/neuron_accumulator.sv
// Neuron compute stage: multiply-accumulates N activation/weight pairs on top
// of a bias, formats the sum to Q8.8 (shift, saturate, optional ReLU) and
// emits one write-back beat.
//   clk, reset                    : clock, synchronous active-high reset
//   start, num_terms, dest_addr,
//   bias_in, relu_en              : neuron launch and its configuration
//   in_valid, in_ready,
//   act_in, weight_in             : operand stream handshake
//   busy                          : not IDLE
//   wr_en, wr_addr, wr_data, done : registered write-back beat
module neuron_accumulator #(
  parameter int DATA_W    = mlp_pkg::DATA_W,
  parameter int ADDR_W    = mlp_pkg::ADDR_W,
  parameter int FRAC_BITS = mlp_pkg::FRAC_BITS,
  parameter int ACC_W     = 48,
  parameter int CNT_W     = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_terms,
  input  logic [ADDR_W-1:0]        dest_addr,
  input  logic signed [DATA_W-1:0] bias_in,
  input  logic                     relu_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] act_in,
  input  logic signed [DATA_W-1:0] weight_in,
  output logic                     busy,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     done
);

  import mlp_pkg::*;

  state_e                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           n_q, n_d;
  logic [ADDR_W-1:0]          dest_q, dest_d;
  logic                       relu_q, relu_d;
  logic                       in_ready_q, in_ready_d;
  logic                       busy_q, busy_d;
  logic                       wr_en_q, wr_en_d;
  logic                       done_q, done_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic signed [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   fmt_data;
  logic                       beat;

  assign prod = act_in * weight_in;
  assign beat = (state_q == ACCUM) && in_valid;

  sat_relu #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_sat_relu (
    .acc_i (acc_q),
    .relu_i(relu_q),
    .data_o(fmt_data)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    dest_d    = dest_q;
    relu_d    = relu_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = num_terms;
          dest_d = dest_addr;
          relu_d = relu_en;
          acc_d  = ACC_W'(bias_in) <<< FRAC_BITS;
          cnt_d  = '0;
          // A zero-term neuron is just the formatted bias.
          state_d = (num_terms == '0) ? FINISH : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_q + ACC_W'(prod);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == n_q - CNT_W'(1)) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        wr_data_d = fmt_data;
        wr_addr_d = dest_q;
        state_d   = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != IDLE);
    wr_en_d    = (state_d == WRITE);
    done_d     = (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      dest_q     <= '0;
      relu_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      dest_q     <= dest_d;
      relu_q     <= relu_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign wr_en    = wr_en_q;
  assign done     = done_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule : neuron_accumulator

// File: tb/tb_neuron_accumulator.sv
// Scoreboard bench for neuron_accumulator: directed neurons push their
// expected write-back (address, data, cycle) into a queue; a monitor pops and
// compares whenever wr_en is seen.
module tb_neuron_accumulator;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [11:0]        num_terms;
  logic [11:0]        dest_addr;
  logic signed [15:0] bias_in;
  logic               relu_en;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] act_in;
  logic signed [15:0] weight_in;
  logic               busy;
  logic               wr_en;
  logic [11:0]        wr_addr;
  logic signed [15:0] wr_data;
  logic               done;

  neuron_accumulator dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_terms(num_terms),
    .dest_addr(dest_addr),
    .bias_in  (bias_in),
    .relu_en  (relu_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .act_in   (act_in),
    .weight_in(weight_in),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int due;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  int act_v [8];
  int wt_v  [8];

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every write-back must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (q.size() == 0) begin
          chk("unexpected_wr_en", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("wr_data", int'(wr_data), e.data);
          chk("wr_cycle", cyc, e.due);
          chk("done_with_wr_en", int'(done), 1);
        end
      end else if (done) begin
        chk("done_without_wr_en", 1, 0);
      end
    end
  end

  // Launch one neuron using act_v/wt_v, optionally with a bubble before every
  // beat after the first, and register its expected write-back.
  task automatic run_neuron(input int n, input int bias, input bit relu,
                            input int dest, input bit gaps, input int exp_d);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; num_terms = 12'(n); bias_in = 16'(bias);
    relu_en = relu; dest_addr = 12'(dest);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        chk("in_ready_bubble", int'(in_ready), 1);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; act_in = 16'(act_v[i]); weight_in = 16'(wt_v[i]);
      chk("in_ready_beat", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    e.addr = dest; e.data = exp_d; e.due = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_terms = '0; dest_addr = '0;
    bias_in = '0; relu_en = 1'b0; in_valid = 1'b0; act_in = '0; weight_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    reset = 1'b0;

    // Basic MAC: (256+512-256)*256 = 131072 -> 512.
    act_v[0] = 256; act_v[1] = 512; act_v[2] = -256;
    wt_v[0]  = 256; wt_v[1]  = 256; wt_v[2]  = 256;
    run_neuron(3, 0, 1'b0, 'h010, 1'b0, 512);

    // ReLU on and off.
    act_v[0] = -256; wt_v[0] = 256;
    run_neuron(1, 0, 1'b1, 'h020, 1'b0, 0);
    run_neuron(1, 0, 1'b0, 'h021, 1'b0, -256);

    // Saturation both directions.
    act_v[0] = 32767; act_v[1] = 32767; wt_v[0] = 32767; wt_v[1] = 32767;
    run_neuron(2, 0, 1'b0, 'h030, 1'b0, 32767);
    act_v[0] = -32768; act_v[1] = -32768;
    run_neuron(2, 0, 1'b0, 'h031, 1'b0, -32768);

    // Bias only.
    run_neuron(0, 384, 1'b0, 'hABC, 1'b0, 384);

    // Bias plus one term: -128 + 256 = 128.
    act_v[0] = 256; wt_v[0] = 256;
    run_neuron(1, -128, 1'b0, 'h040, 1'b0, 128);

    // Tiny negative product truncates toward -inf: -1/256 -> -1.
    act_v[0] = -1; wt_v[0] = 1;
    run_neuron(1, 0, 1'b0, 'h041, 1'b0, -1);

    // Same 4-term sum gap-free and with bubbles: (256+512-256+128) -> 640.
    act_v[0] = 256; act_v[1] = 512; act_v[2] = -256; act_v[3] = 128;
    wt_v[0] = 256; wt_v[1] = 256; wt_v[2] = 256; wt_v[3] = 256;
    run_neuron(4, 0, 1'b0, 'h050, 1'b0, 640);
    run_neuron(4, 0, 1'b0, 'h051, 1'b1, 640);

    // Reset after 2 of 3 beats: aborted, outputs cleared, no write-back.
    @(posedge clk); #1;
    start = 1'b1; num_terms = 12'd3; dest_addr = 12'h123; bias_in = 16'sd0;
    relu_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; act_in = 16'sd256; weight_in = 16'sd256;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_wr_addr", int'(wr_addr), 0);
    chk("abort_wr_data", int'(wr_data), 0);
    reset = 1'b0;

    // start pulsed during ACCUM is ignored: 2*256 + 1*256 = 768 -> 3 at dest 0x055.
    @(posedge clk); #1;
    start = 1'b1; num_terms = 12'd2; dest_addr = 12'h055; bias_in = 16'sd0;
    relu_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; act_in = 16'sd512; weight_in = 16'sd256;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b1; num_terms = 12'd0; dest_addr = 12'h0FF; bias_in = 16'sd1000;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; act_in = 16'sd256; weight_in = 16'sd256;
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      exp_t e;
      e.addr = 'h055; e.data = 768; e.due = cyc + 1;
      q.push_back(e);
    end

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_neuron_accumulator
